// File: rtl/noc_pkg.sv
// Shared definitions for the PE network interface: flit field offsets,
// flit width computation and a flit struct at the default geometry.
package noc_pkg;

   // Default geometry (1-bit X/Y fields, 256-bit payload)
   localparam int DEF_X_SIZE = 1;
   localparam int DEF_Y_SIZE = 1;
   localparam int DEF_DATA_W = 256;

   // Flit field offsets at the default geometry; X always sits at bit 0
   localparam int X_LSB    = 0;
   localparam int Y_LSB    = DEF_X_SIZE;
   localparam int DATA_LSB = DEF_X_SIZE + DEF_Y_SIZE;

   // Field offsets for an arbitrary geometry
   function automatic int f_y_lsb(input int xs);
      return X_LSB + xs;
   endfunction

   function automatic int f_data_lsb(input int xs, input int ys);
      return X_LSB + xs + ys;
   endfunction

   // Full flit width: {data, y, x}
   function automatic int f_total_width(input int xs, input int ys, input int dw);
      return xs + ys + dw;
   endfunction

   // Flit layout, MSB first: payload, dest Y, dest X
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_Y_SIZE-1:0] y;
      logic [DEF_X_SIZE-1:0] x;
   } flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The caller decides legality of push/pop; the FIFO simply performs them,
// so a push into a full FIFO is only safe when paired with a pop.
module noc_sync_fifo
   import noc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [PTR_W-1:0]            r_wr_ptr;
   logic [PTR_W-1:0]            r_rd_ptr;
   logic [CNT_W-1:0]            r_count;

   // Storage, pointers (wrap naturally, depth is a power of 2) and count
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/noc_pe_interface.sv
// Network interface between a PE and the PE port of one mesh/torus switch.
// TX: PE payload + destination is packed into a flit {data, y, x}, buffered
// and injected under switch backpressure. RX: ejected flits are always sunk
// (no backpressure from the switch); overflow and misroute are sticky flags.
// Optional statistics counters are enabled by defining NOC_PE_STATS_EN.
module noc_pe_interface
   import noc_pkg::*;
#(
   parameter int x_coord     = 0,
   parameter int y_coord     = 0,
   parameter int x_size      = 1,
   parameter int y_size      = 1,
   parameter int data_width  = 256,
   parameter int total_width = f_total_width(x_size, y_size, data_width),
   parameter int TX_DEPTH    = 4,
   parameter int RX_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [data_width-1:0]         s_data,
   input  logic [x_size-1:0]             s_dest_x,
   input  logic [y_size-1:0]             s_dest_y,
   output logic                          o_noc_valid,
   input  logic                          i_noc_ready,
   output logic [total_width-1:0]        o_noc_data,
   input  logic                          i_noc_valid,
   input  logic [total_width-1:0]        i_noc_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [data_width-1:0]         m_data,
   output logic [$clog2(TX_DEPTH):0]     o_tx_count,
   output logic [$clog2(RX_DEPTH):0]     o_rx_count,
`ifdef NOC_PE_STATS_EN
   output logic [31:0]                   o_tx_flits,
   output logic [31:0]                   o_rx_flits,
   output logic [31:0]                   o_tx_stall_cycles,
`endif
   output logic                          o_rx_overflow,
   output logic                          o_rx_misroute
);

   localparam int Y_OFF    = f_y_lsb(x_size);
   localparam int DATA_OFF = f_data_lsb(x_size, y_size);

   // ---------------- TX path ----------------
   logic                   w_tx_push;
   logic                   w_tx_pop;
   logic                   w_tx_full;
   logic                   w_tx_empty;
   logic [total_width-1:0] w_tx_flit;

   // A full TX FIFO refuses pushes even if a pop happens the same cycle,
   // keeping s_ready a pure function of stored state.
   assign s_ready     = !w_tx_full;
   assign w_tx_push   = s_valid & !w_tx_full;
   assign o_noc_valid = !w_tx_empty;
   assign w_tx_pop    = !w_tx_empty & i_noc_ready;
   assign w_tx_flit   = {s_data, s_dest_y, s_dest_x};

   noc_sync_fifo #(
      .WIDTH (total_width),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_tx_push),
      .i_data  (w_tx_flit),
      .i_pop   (w_tx_pop),
      .o_data  (o_noc_data),
      .o_count (o_tx_count),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   // ---------------- RX path ----------------
   logic                  w_rx_push;
   logic                  w_rx_pop;
   logic                  w_rx_full;
   logic                  w_rx_empty;
   logic                  w_rx_drop;
   logic                  w_rx_misroute;
   logic [x_size-1:0]     w_rx_x;
   logic [y_size-1:0]     w_rx_y;
   logic [data_width-1:0] w_rx_payload;
   logic                  r_rx_overflow;
   logic                  r_rx_misroute;

   assign w_rx_x       = i_noc_data[X_LSB +: x_size];
   assign w_rx_y       = i_noc_data[Y_OFF +: y_size];
   assign w_rx_payload = i_noc_data[DATA_OFF +: data_width];

   // The ejection port cannot be stalled, so a full RX FIFO still takes a
   // flit when the PE drains one in the same cycle.
   assign m_valid       = !w_rx_empty;
   assign w_rx_pop      = !w_rx_empty & m_ready;
   assign w_rx_push     = i_noc_valid & (!w_rx_full | w_rx_pop);
   assign w_rx_drop     = i_noc_valid & !w_rx_push;
   assign w_rx_misroute = i_noc_valid &
                          ((w_rx_x != x_size'(x_coord)) | (w_rx_y != y_size'(y_coord)));

   noc_sync_fifo #(
      .WIDTH (data_width),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_rx_push),
      .i_data  (w_rx_payload),
      .i_pop   (w_rx_pop),
      .o_data  (m_data),
      .o_count (o_rx_count),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_overflow <= 1'b0;
         r_rx_misroute <= 1'b0;
      end else begin
         if (w_rx_drop)     r_rx_overflow <= 1'b1;
         if (w_rx_misroute) r_rx_misroute <= 1'b1;
      end
   end

   assign o_rx_overflow = r_rx_overflow;
   assign o_rx_misroute = r_rx_misroute;

`ifdef NOC_PE_STATS_EN
   logic [31:0] r_tx_flits;
   logic [31:0] r_rx_flits;
   logic [31:0] r_tx_stall_cycles;

   // Free-running traffic counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tx_flits        <= '0;
         r_rx_flits        <= '0;
         r_tx_stall_cycles <= '0;
      end else begin
         if (w_tx_pop)                    r_tx_flits        <= r_tx_flits + 32'd1;
         if (w_rx_push)                   r_rx_flits        <= r_rx_flits + 32'd1;
         if (o_noc_valid & !i_noc_ready)  r_tx_stall_cycles <= r_tx_stall_cycles + 32'd1;
      end
   end

   assign o_tx_flits        = r_tx_flits;
   assign o_rx_flits        = r_rx_flits;
   assign o_tx_stall_cycles = r_tx_stall_cycles;
`endif

endmodule
